// File: rtl/uart_serial_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling deframer (start/data/parity/stop)
// and a single-entry valid/ready output register with parity, framing and overrun pulses.
module uart_serial_rx #(
    parameter int unsigned BAUD_DIV   = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    input  logic                 Rx_Ready,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(BAUD_DIV / 2 - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 deliver_q, deliver_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 par_err_q, par_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rxs;

    assign rxs = sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (prev_q && !rxs) begin
                    // The detection cycle already counts toward the half bit.
                    state_d   = StStart;
                    cnt_d     = CntW'(1);
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    state_d = rxs ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BitLast) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    par_bad_d = ((^shift_q) ^ rxs) != PARITY_ODD;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rxs) begin
                        deliver_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output register: an accept and a delivery in the same cycle chain without overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        par_err_d = 1'b0;
        overrun_d = 1'b0;
        if (valid_q && Rx_Ready) begin
            valid_d = 1'b0;
        end
        if (deliver_q) begin
            par_err_d = par_bad_q;
            if (valid_q && !Rx_Ready) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            deliver_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= RxD;
            sync2_q     <= sync1_q;
            prev_q      <= rxs;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_bad_q   <= par_bad_d;
            deliver_q   <= deliver_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign Rx_Data    = data_q;
    assign Rx_Valid   = valid_q;
    assign Parity_Err = par_err_q;
    assign Frame_Err  = frame_err_q;
    assign Overrun    = overrun_q;
    assign Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_serial_rx.sv
// Directed bench: an 8N1 receiver and an 8E1 receiver driven with hand-built frames.
module tb_uart_serial_rx;

    localparam int B = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       ready = 1'b1;
    logic       rxd_p = 1'b1;
    logic       ready_p = 1'b1;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, par_err, frame_err, overrun, busy;
    logic       rx_valid_p, par_err_p, frame_err_p, overrun_p, busy_p;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_serial_rx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
        .Clk(clk), .Rst(rst), .RxD(rxd), .Rx_Data(rx_data), .Rx_Valid(rx_valid),
        .Rx_Ready(ready), .Parity_Err(par_err), .Frame_Err(frame_err), .Overrun(overrun),
        .Busy(busy)
    );

    uart_serial_rx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
        .Clk(clk), .Rst(rst), .RxD(rxd_p), .Rx_Data(rx_data_p), .Rx_Valid(rx_valid_p),
        .Rx_Ready(ready_p), .Parity_Err(par_err_p), .Frame_Err(frame_err_p),
        .Overrun(overrun_p), .Busy(busy_p)
    );

    // Event counters sampled mid-cycle; stimulus takes snapshots and checks deltas.
    logic vld_prev = 1'b0;
    logic vld_p_prev = 1'b0;
    int   n_vrise = 0, n_vhigh = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, last_rise = 0;
    int   n_vrise_p = 0, n_perr_p = 0, n_pc_p = 0, last_rise_p = 0;

    always @(negedge clk) begin
        vld_prev   <= rx_valid;
        vld_p_prev <= rx_valid_p;
        if (rx_valid && !vld_prev) begin
            n_vrise   <= n_vrise + 1;
            last_rise <= cyc;
        end
        if (rx_valid)  n_vhigh <= n_vhigh + 1;
        if (frame_err) n_ferr  <= n_ferr + 1;
        if (overrun)   n_ovr   <= n_ovr + 1;
        if (par_err)   n_perr  <= n_perr + 1;
        if (rx_valid_p && !vld_p_prev) begin
            n_vrise_p   <= n_vrise_p + 1;
            last_rise_p <= cyc;
        end
        if (par_err_p) n_perr_p <= n_perr_p + 1;
        if (par_err_p && rx_valid_p && !vld_p_prev) n_pc_p <= n_pc_p + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit to_p, input logic v, input int n);
        if (to_p) rxd_p = v;
        else rxd = v;
        repeat (n) tick();
    endtask

    task automatic send_frame(input bit to_p, input logic [7:0] d, input bit par_en,
                              input logic par_bit, input logic stop_bit);
        last_start = cyc;
        drive_bit(to_p, 1'b0, B);
        for (int i = 0; i < 8; i++) drive_bit(to_p, d[i], B);
        if (par_en) drive_bit(to_p, par_bit, B);
        drive_bit(to_p, stop_bit, B);
    endtask

    int s_vr, s_vh, s_fe, s_ov, s_pe, s_vrp, s_pep, s_pcp;

    task automatic snap();
        s_vr = n_vrise; s_vh = n_vhigh; s_fe = n_ferr; s_ov = n_ovr; s_pe = n_perr;
        s_vrp = n_vrise_p; s_pep = n_perr_p; s_pcp = n_pc_p;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_data", {24'd0, rx_data}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_flags", {29'd0, par_err, frame_err, overrun}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // T1: 0x55, 8N1, always ready
        snap();
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        check_eq("t1_data", {24'd0, rx_data}, 32'h55);
        check_eq("t1_latency", last_rise - last_start, 32'd155);
        check_eq("t1_vrise", n_vrise - s_vr, 32'd1);
        check_eq("t1_vhigh", n_vhigh - s_vh, 32'd1);
        check_eq("t1_flags", (n_ferr - s_fe) + (n_ovr - s_ov) + (n_perr - s_pe), 32'd0);

        // T2: back-to-back with consumer stalled
        ready = 1'b0;
        snap();
        send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        check_eq("t2_data_held", {24'd0, rx_data}, 32'hA3);
        check_eq("t2_valid_held", {31'd0, rx_valid}, 32'd1);
        check_eq("t2_overrun", n_ovr - s_ov, 32'd1);
        check_eq("t2_vrise", n_vrise - s_vr, 32'd1);
        ready = 1'b1;
        tick();
        check_eq("t2_accept_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("t2_accept_data", {24'd0, rx_data}, 32'hA3);

        // T3: even parity, 0x07 with a wrong then a right parity bit
        snap();
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (4) tick();
        check_eq("t3_data", {24'd0, rx_data_p}, 32'h07);
        check_eq("t3_latency", last_rise_p - last_start, 32'd171);
        check_eq("t3_perr_coinc", n_pc_p - s_pcp, 32'd1);
        check_eq("t3_perr_count", n_perr_p - s_pep, 32'd1);
        snap();
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        repeat (4) tick();
        check_eq("t3_ok_vrise", n_vrise_p - s_vrp, 32'd1);
        check_eq("t3_ok_perr", n_perr_p - s_pep, 32'd0);

        // T4: stop bit low, then a 40 bit-time break
        snap();
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
        repeat (40 * B) tick();
        check_eq("t4_busy_break", {31'd0, busy}, 32'd1);
        check_eq("t4_ferr", n_ferr - s_fe, 32'd1);
        check_eq("t4_no_valid", n_vrise - s_vr, 32'd0);
        rxd = 1'b1;
        repeat (4) tick();
        check_eq("t4_busy_idle", {31'd0, busy}, 32'd0);
        repeat (B) tick();
        snap();
        send_frame(1'b0, 8'h42, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        check_eq("t4_recover_data", {24'd0, rx_data}, 32'h42);
        check_eq("t4_recover_vrise", n_vrise - s_vr, 32'd1);

        // T5: 4-clock low glitch is a false start
        snap();
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        tick();
        check_eq("t5_busy_start", {31'd0, busy}, 32'd1);
        repeat (B / 2 + 3 - 5) tick();
        check_eq("t5_busy_done", {31'd0, busy}, 32'd0);
        repeat (2 * B) tick();
        check_eq("t5_quiet", (n_vrise - s_vr) + (n_ferr - s_fe) + (n_ovr - s_ov)
                 + (n_perr - s_pe), 32'd0);

        // T6: reset in the middle of 0xFF
        snap();
        drive_bit(1'b0, 1'b0, B);
        drive_bit(1'b0, 1'b1, 3 * B);
        check_eq("t6_busy_mid", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check_eq("t6_rst_data", {24'd0, rx_data}, 32'd0);
        check_eq("t6_rst_busy_valid", {30'd0, busy, rx_valid}, 32'd0);
        rst = 1'b0;
        repeat (10 * B) tick();
        check_eq("t6_no_byte", (n_vrise - s_vr) + (n_ferr - s_fe), 32'd0);
        snap();
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        check_eq("t6_next_data", {24'd0, rx_data}, 32'h11);
        check_eq("t6_next_vrise", n_vrise - s_vr, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
